// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5-9 data bits, none/even/odd parity, 1-2 stop bits.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_rx_param #(
  parameter int unsigned CLOCK_RATE = 12000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxEn,
  input  logic                 rxIn,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxErr,
  output logic                 rxParityErr,
  output logic [DATA_BITS-1:0] rxOut
);

  localparam int unsigned Div  = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DivW = $clog2(Div + 1);
  localparam int unsigned PhW  = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam int unsigned Half = OVERSAMPLE / 2;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [2:0]           state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [PhW-1:0]       ph_q, ph_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 done_q, done_d, err_q, err_d, par_err_q, par_err_d;
  logic [DATA_BITS-1:0] out_q, out_d;

  logic tick, fall, bit_evt, bit_val, par_exp;

  assign tick    = (div_q == DivW'(Div - 1));
  assign fall    = rx_prev_q & ~rx_s_q;
  assign par_exp = (PARITY == 2) ? ~^shift_q : ^shift_q;

`ifdef UART_RX_MAJORITY_EN
  // Votes are taken at ticks Half-1 and Half; the decision lands on tick Half+1.
  logic [1:0] vote_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vote_q <= 2'b11;
    end else if (tick && state_q != StIdle) begin
      if (ph_q == PhW'(Half - 2)) vote_q[0] <= rx_s_q;
      if (ph_q == PhW'(Half - 1)) vote_q[1] <= rx_s_q;
    end
  end

  assign bit_evt = tick && (ph_q == PhW'(Half));
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
  assign bit_evt = tick && (ph_q == PhW'(Half - 1));
  assign bit_val = rx_s_q;
`endif

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    ph_d       = ph_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;
    err_d      = err_q;
    par_err_d  = par_err_q;
    out_d      = out_q;

    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) ph_d = (ph_q == PhW'(OVERSAMPLE - 1)) ? '0 : ph_q + PhW'(1);
    end

    if (state_q != StIdle && !rxEn) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          div_d = '0;
          ph_d  = '0;
          if (rxEn && fall) begin
            state_d    = StStart;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
          end
        end
        StStart: if (bit_evt) state_d = bit_val ? StIdle : StData;
        StData: begin
          if (bit_evt) begin
            shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BitW'(1);
            if (bit_cnt_q == BitW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? StParity : StStop;
          end
        end
        StParity: begin
          if (bit_evt) begin
            perr_d  = (bit_val != par_exp);
            state_d = StStop;
          end
        end
        StStop: begin
          if (bit_evt) begin
            ferr_d = ferr_q | ~bit_val;
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              // Leave at mid-stop so a following start edge is not missed.
              out_d     = shift_q;
              err_d     = ferr_q | ~bit_val;
              par_err_d = perr_q;
              done_d    = 1'b1;
              state_d   = StIdle;
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      div_q      <= '0;
      ph_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      par_err_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      rx_meta_q  <= rxIn;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      div_q      <= div_d;
      ph_q       <= ph_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      par_err_q  <= par_err_d;
      out_q      <= out_d;
    end
  end

  assign rxBusy      = (state_q != StIdle);
  assign rxDone      = done_q;
  assign rxErr       = err_q;
  assign rxParityErr = par_err_q;
  assign rxOut       = out_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8N1 channel plus parity, two-stop and
// 9-bit channels running at a faster baud divider (DIV=8, 128 clk per bit).
module tb_uart_rx_param;

  localparam int BitDef  = 1248;
  localparam int BitFast = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, line;
  int   sel;
  logic in_def, in_par, in_st2, in_d9;

  assign in_def = (sel == 0) ? line : 1'b1;
  assign in_par = (sel == 1) ? line : 1'b1;
  assign in_st2 = (sel == 2) ? line : 1'b1;
  assign in_d9  = (sel == 3) ? line : 1'b1;

  logic       busy_def, done_def, err_def, perr_def;
  logic [7:0] out_def;
  logic       busy_par, done_par, err_par, perr_par;
  logic [7:0] out_par;
  logic       busy_st2, done_st2, err_st2, perr_st2;
  logic [7:0] out_st2;
  logic       busy_d9, done_d9, err_d9, perr_d9;
  logic [8:0] out_d9;

  uart_rx_param u_def (
    .clk(clk), .reset(rst_n), .rxEn(en), .rxIn(in_def), .rxBusy(busy_def),
    .rxDone(done_def), .rxErr(err_def), .rxParityErr(perr_def), .rxOut(out_def)
  );

  uart_rx_param #(.CLOCK_RATE(1228800), .PARITY(1)) u_par (
    .clk(clk), .reset(rst_n), .rxEn(en), .rxIn(in_par), .rxBusy(busy_par),
    .rxDone(done_par), .rxErr(err_par), .rxParityErr(perr_par), .rxOut(out_par)
  );

  uart_rx_param #(.CLOCK_RATE(1228800), .STOP_BITS(2)) u_st2 (
    .clk(clk), .reset(rst_n), .rxEn(en), .rxIn(in_st2), .rxBusy(busy_st2),
    .rxDone(done_st2), .rxErr(err_st2), .rxParityErr(perr_st2), .rxOut(out_st2)
  );

  uart_rx_param #(.CLOCK_RATE(1228800), .DATA_BITS(9)) u_d9 (
    .clk(clk), .reset(rst_n), .rxEn(en), .rxIn(in_d9), .rxBusy(busy_d9),
    .rxDone(done_d9), .rxErr(err_d9), .rxParityErr(perr_d9), .rxOut(out_d9)
  );

  int dn_def = 0, dn_par = 0, dn_st2 = 0, dn_d9 = 0;
  logic [8:0] d9_log0 = '0, d9_log1 = '0;

  always @(posedge clk) begin
    if (done_def) dn_def <= dn_def + 1;
    if (done_par) dn_par <= dn_par + 1;
    if (done_st2) dn_st2 <= dn_st2 + 1;
    if (done_d9) begin
      dn_d9 <= dn_d9 + 1;
      if (dn_d9 == 0) d9_log0 <= out_d9;
      if (dn_d9 == 1) d9_log1 <= out_d9;
    end
  end

  logic busy_sel;
  always_comb begin
    busy_sel = 1'b0;
    case (sel)
      0: busy_sel = busy_def;
      1: busy_sel = busy_par;
      2: busy_sel = busy_st2;
      3: busy_sel = busy_d9;
      default: busy_sel = 1'b0;
    endcase
  end

  int   pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  logic busy_at_start;
  int   d0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives bits[0..n-1] LSB first, each held for 'period' clocks.
  task automatic send_bits(input logic [15:0] bits, input int n, input int period);
    for (int i = 0; i < n; i++) begin
      line = bits[i];
      if (i == 0) begin
        tick_n(3);
        busy_at_start = busy_sel;
        tick_n(period - 3);
      end else begin
        tick_n(period);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    line  = 1'b1;
    sel   = 0;
    busy_at_start = 1'b0;
    tick_n(5);
    check("rst_busy", 16'(busy_def), 16'h0);
    check("rst_done", 16'(done_def), 16'h0);
    check("rst_err", 16'(err_def), 16'h0);
    check("rst_perr", 16'(perr_def), 16'h0);
    check("rst_out", 16'(out_def), 16'h0);
    rst_n = 1'b1;
    tick_n(5);

    // 8N1 0x35 at the default rate
    d0 = dn_def;
    send_bits({6'b0, 1'b1, 8'h35, 1'b0}, 10, BitDef);
    tick_n(10);
    check("def_busy_start", 16'(busy_at_start), 16'h1);
    check("def_done_cnt", 16'(dn_def - d0), 16'h1);
    check("def_out", 16'(out_def), 16'h35);
    check("def_err", 16'(err_def), 16'h0);
    check("def_perr", 16'(perr_def), 16'h0);

    // 300-clk low glitch on idle line: false start
    d0 = dn_def;
    line = 1'b0;
    tick_n(3);
    check("glitch_busy_hi", 16'(busy_def), 16'h1);
    tick_n(297);
    line = 1'b1;
    tick_n(700);
    check("glitch_busy_lo", 16'(busy_def), 16'h0);
    check("glitch_no_done", 16'(dn_def - d0), 16'h0);
    check("glitch_out", 16'(out_def), 16'h35);

    // rxEn dropped during data bit 4 (0xC3 bit 4 = 0)
    d0 = dn_def;
    send_bits({6'b0, 1'b1, 8'hC3, 1'b0}, 5, BitDef);
    line = 1'b0;
    tick_n(600);
    en = 1'b0;
    tick_n(1);
    check("abort_busy", 16'(busy_def), 16'h0);
    line = 1'b1;
    tick_n(20);
    en = 1'b1;
    tick_n(BitDef * 6);
    check("abort_no_done", 16'(dn_def - d0), 16'h0);
    check("abort_out", 16'(out_def), 16'h35);

    // Asynchronous reset during data bit 4
    send_bits({6'b0, 1'b1, 8'hC3, 1'b0}, 5, BitDef);
    line = 1'b0;
    tick_n(600);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 16'(busy_def), 16'h0);
    check("mrst_done", 16'(done_def), 16'h0);
    check("mrst_err", 16'(err_def), 16'h0);
    check("mrst_perr", 16'(perr_def), 16'h0);
    check("mrst_out", 16'(out_def), 16'h0);
    tick_n(2);
    line = 1'b1;
    rst_n = 1'b1;
    tick_n(10);
    d0 = dn_def;
    send_bits({6'b0, 1'b1, 8'h35, 1'b0}, 10, BitDef);
    tick_n(10);
    check("post_rst_done", 16'(dn_def - d0), 16'h1);
    check("post_rst_out", 16'(out_def), 16'h35);

`ifdef UART_RX_MAJORITY_EN
    // 1-clk high glitch near mid of data bit 2 of 0x3A (bit 2 = 0)
    send_bits({6'b0, 1'b1, 8'h3A, 1'b0}, 3, BitDef);
    line = 1'b0;
    tick_n(626);
    line = 1'b1;
    tick_n(1);
    line = 1'b0;
    tick_n(BitDef - 627);
    send_bits({10'b0, 1'b1, 5'b00111}, 6, BitDef);
    tick_n(10);
    check("maj_glitch_out", 16'(out_def), 16'h3A);
`endif

    // Even parity: 0x35 has four ones, so correct parity bit is 0
    sel = 1;
    tick_n(5);
    send_bits({5'b0, 1'b1, 1'b1, 8'h35, 1'b0}, 11, BitFast);
    tick_n(10);
    check("par_bad_out", 16'(out_par), 16'h35);
    check("par_bad_perr", 16'(perr_par), 16'h1);
    check("par_bad_err", 16'(err_par), 16'h0);
    send_bits({5'b0, 1'b1, 1'b0, 8'h35, 1'b0}, 11, BitFast);
    tick_n(10);
    check("par_ok_perr", 16'(perr_par), 16'h0);
    check("par_ok_done", 16'(dn_par), 16'h2);

    // Two stop bits, second one low
    sel = 2;
    tick_n(5);
    send_bits({5'b0, 1'b0, 1'b1, 8'hA5, 1'b0}, 11, BitFast);
    line = 1'b1;
    tick_n(10);
    check("st2_err", 16'(err_st2), 16'h1);
    check("st2_out", 16'(out_st2), 16'hA5);
    check("st2_done", 16'(dn_st2), 16'h1);

    // 9-bit frames back to back
    sel = 3;
    tick_n(5);
    send_bits({5'b0, 1'b1, 9'h1C3, 1'b0}, 11, BitFast);
    send_bits({5'b0, 1'b1, 9'h055, 1'b0}, 11, BitFast);
    tick_n(10);
    check("d9_done_cnt", 16'(dn_d9), 16'h2);
    check("d9_first", 16'(d9_log0), 16'h1C3);
    check("d9_second", 16'(d9_log1), 16'h055);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; the next generation of the existing fixed 8N1 Uart8 rx path.
- Adds configurable data width (5-9), parity (none/even/odd), 1 or 2 stop bits, separate parity-error flag and false-start rejection.
- Sits between the board RX pin and byte-consuming logic. A single instance serves one channel.

Parameters:
- CLOCK_RATE, 12000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in baud.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and >= 8.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- rxEn  in  1  receive enable
- rxIn  in  1  serial line; idle level is high
- rxBusy  out  1  high while a frame is in progress (START..STOP)
- rxDone  out  1  one-cycle pulse when a frame completes
- rxErr  out  1  framing error: a stop bit was sampled low
- rxParityErr  out  1  parity mismatch. Always 0 when PARITY=0.
- rxOut  out  DATA_BITS  received word, LSB = first bit received

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset).
- Reset values: rxBusy=0, rxDone=0, rxErr=0, rxParityErr=0, rxOut=0. Synchroniser flops reset to 1. State = IDLE.
- Input synchronisation: rxIn passes through a 2-flop synchroniser. All logic uses the synchronised value rxS.
- Tick generator: divider DIV = CLOCK_RATE/(BAUD_RATE*OVERSAMPLE), integer truncation. Emits a 1-cycle tick every DIV clks. It is held cleared in IDLE and restarts on start detection.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rxEn=1 and a falling edge on rxS -> START, rxBusy=1, tick/sample counters cleared.
  - rxEn=0 -> the falling edge is ignored.
- START: at tick OVERSAMPLE/2, sample the line.
  - Sample = 1: false start. Go to IDLE, rxBusy=0, no flags change.
  - Sample = 0: go to DATA. All later samples are taken every OVERSAMPLE ticks, mid-bit.
- DATA:
  - Shift in DATA_BITS bits, LSB first.
  - After the last bit: go to PARITY if PARITY != 0, otherwise to STOP.
- PARITY:
  - Expected bit = XOR of data bits for even, XNOR for odd.
  - A mismatch sets the internal parity flag.
- STOP:
  - Sample STOP_BITS bits. Any sample of 0 sets the internal framing flag.
  - After the final stop sample, on the next clk:
    - rxOut <= shift register.
    - rxErr, rxParityErr <= internal flags.
    - rxDone = 1 for exactly one cycle.
    - rxBusy = 0, state = IDLE.
  - Return to IDLE at mid-stop, so back-to-back frames are accepted.
- Output hold:
  - rxOut holds its value until the next rxDone.
  - rxErr and rxParityErr hold until the next frame's rxDone or reset. They are not cleared on start.
- On a framing or parity error: rxOut is still updated, and rxDone still pulses.
- rxEn deasserted mid-frame: abort on the next clk. State = IDLE, rxBusy=0, no rxDone. rxOut and flags are unchanged.
- Line low when IDLE is entered (stuck low or break): no new start until rxS has been seen high for at least one clk (edge-detect rule).
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronous). The partial frame is discarded.
- rxDone and a new falling edge in the same cycle: the edge is accepted and rxBusy re-asserts on the following cycle.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The false-start check uses the same vote.
- Undefined: a single sample at tick OVERSAMPLE/2. The vote logic is not synthesised.

Test Plan:
- Defaults; DIV=78, bit = 1248 clk cycles. Send 8N1 frame of 0x35 at 1248 clk/bit -> rxBusy high within 3 clk of the start edge; one rxDone pulse; rxOut=0x35; rxErr=0; rxParityErr=0.
- PARITY=1, 0x35 with parity bit 1 (correct value 0) -> rxOut=0x35, rxParityErr=1, rxErr=0. Repeat with parity 0 -> rxParityErr=0.
- STOP_BITS=2, 0xA5 with the second stop bit low -> rxErr=1, rxOut=0xA5, rxDone pulses once.
- Low glitch of 300 clk on an idle line -> rxBusy rises then falls; no rxDone; rxOut unchanged. With UART_RX_MAJORITY_EN, a 1-clk-wide high glitch at mid-bit of data bit 2 is rejected -> rxOut correct.
- DATA_BITS=9, send 0x1C3, then a 0x055 frame back-to-back with no idle gap -> two rxDone pulses; rxOut=0x1C3 then 0x055.
- Mid-frame abort: rxEn=0 during bit 4 -> rxBusy=0 next clk, no rxDone. Separately, reset low during bit 4 -> all outputs 0 immediately. After release, a full 0x35 frame is received correctly.
